data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Data-memory responder: the other end of the memRead/memWrite/memtoReg interface driven by the main-decoder control unit.
- Accepts one load or store per request from the datapath's MEM stage.
- Performs the access after a configurable number of wait states, then returns read data with a one-cycle ready pulse.
- Flags protocol violations: misaligned address, or read and write requested together.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 8, word-index width; DEPTH = 2**ADDR_W words.
- WAIT_CYCLES, 2, wait states between accept and access; legal range 0..15.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- memRead  in  1  load request.
- memWrite  in  1  store request.
- addr  in  32  byte address from the ALU result.
- writeData  in  DATA_W  store data.
- readData  out  DATA_W  load result, registered.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state != IDLE.
- err  out  1  error status, valid while ready=1.

Behaviour:
- Reset (async assert, reset_n=0):
  - state=IDLE, cnt=0, readData=0, ready=0, err=0, busy=0.
  - Memory array contents are not reset.
- Word index = addr[ADDR_W+1:2]. addr[31:ADDR_W+2] is ignored, so addresses alias modulo DEPTH words.
- Request fields (op, index, writeData) are captured on the accept edge only. Input changes after accept have no effect.
- States: IDLE, WAIT, DONE. cnt is a 4-bit down-counter.
- IDLE, no request: stay in IDLE.
- IDLE, valid request (exactly one of memRead/memWrite high, addr[1:0]==0):
  - Latch the request.
  - cnt <= WAIT_CYCLES.
  - Go to WAIT.
- IDLE, bad request (memRead & memWrite both high, or addr[1:0]!=0):
  - No memory access.
  - Go to DONE with err<=1.
  - readData holds its previous value.
- WAIT, cnt!=0: cnt <= cnt-1, stay in WAIT.
- WAIT, cnt==0: perform the access on this edge and go to DONE with err<=0.
  - Store: mem[index] <= latched writeData.
  - Load: readData <= mem[index], the pre-write contents of the array.
- DONE: ready=1 for exactly this cycle. Next edge returns to IDLE unconditionally.
- Requests present during WAIT or DONE are ignored, not queued.
- The requester must drop memRead/memWrite by the cycle after ready. If they are still high in IDLE, they are accepted as a new request.
- Latency:
  - Valid request: accepted at edge E0, access at edge E(WAIT_CYCLES+1), ready high in the following cycle, IDLE after E(WAIT_CYCLES+2).
  - Error request: ready high in the cycle after E0.
- readData holds its last load result until the next load. Stores and errors do not change it.
- ready, err and busy are all registered or pure state decodes; no combinational input-to-output path.
- Reset mid-operation: any pending store is discarded (not written); outputs take reset values immediately.
- WAIT_CYCLES=0: a single WAIT cycle, access on the edge after accept.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> readData=0, ready=0, busy=0, err=0; release -> IDLE, busy=0.
- Store then load (WAIT_CYCLES=2):
  - memWrite, addr=0x10, writeData=0xDEADBEEF accepted at E0 -> ready pulses one cycle after E3, busy high E0..E3, err=0.
  - Then memRead, addr=0x10 -> readData=0xDEADBEEF with ready.
- Aliasing: store 0x12345678 at addr=0x400 (index 0), then load addr=0x0 -> readData=0x12345678.
- Errors:
  - memRead with addr=0x13 -> ready and err=1 one cycle after accept; readData unchanged; memory unchanged.
  - memRead & memWrite both high -> same err response; no write occurs.
- Reset mid-store: memWrite, addr=0x20, data=0xA5A5A5A5; assert reset_n=0 while in WAIT -> after release, load addr=0x20 returns the prior contents, not 0xA5A5A5A5.
- Held request and ignored requests:
  - Keep memRead high through ready -> second access accepted in the IDLE cycle after DONE.
  - Toggle memWrite during WAIT -> no extra access occurs.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store, waits
// WAIT_CYCLES, performs the access and returns a one-cycle ready pulse.
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    // state | meaning
    // IDLE  | waiting for a request
    // WAIT  | request latched, counting down wait states
    // DONE  | ready pulse, err valid
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                is_wr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic req_any;
    logic req_bad;
    logic access;
    logic unused_addr;

    assign req_any     = memRead | memWrite;
    assign req_bad     = req_any & ((memRead & memWrite) | (|addr[1:0]));
    assign access      = (state_q == WAIT) && (cnt_q == 4'd0);
    // upper address bits are intentionally dropped, giving modulo-DEPTH aliasing
    assign unused_addr = ^addr[31:ADDR_W+2];

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            is_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_bad) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (req_any) begin
                        is_wr_q <= memWrite;
                        idx_q   <= addr[ADDR_W+1:2];
                        wdata_q <= writeData;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!is_wr_q) rdata_q <= mem[idx_q];
                        err_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // array is not reset; a reset during WAIT leaves state IDLE so no write fires
    always_ff @(posedge CLK) begin
        if (access && is_wr_q) mem[idx_q] <= wdata_q;
    end

    assign readData = rdata_q;
    assign ready    = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign err      = err_q;

endmodule
